// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and load-protocol constants
package imem_loader_pkg;

  localparam int COUNT_W        = 16;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    LEN_HI = 3'd0,
    LEN_LO = 3'd1,
    DATA   = 3'd2,
    RUN    = 3'd3,
    ERR    = 3'd4
  } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream, boot control and cpu fetch bus of the loader
interface imem_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        boot_req;
  logic [30:0] cpu_addr;
  logic [31:0] cpu_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  modport master (
    output rx_data, rx_valid, boot_req, cpu_addr,
    input  cpu_data, cpu_hold, load_done, load_err
  );

  modport slave (
    input  rx_data, rx_valid, boot_req, cpu_addr,
    output cpu_data, cpu_hold, load_done, load_err
  );
endinterface

// File: rtl/imem_ram.sv
// rtl/imem_ram.sv - DEPTH x 32 distributed ram, synchronous write, asynchronous read
module imem_ram #(
  parameter int DEPTH = 150,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  // No reset: program contents must survive a reset or an aborted load.
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - uart boot loader filling instruction memory, then serving cpu fetches
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH   = 150,
  parameter int TIMEOUT = 1000000
) (
  input logic         clk,
  input logic         reset,
  imem_loader_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [30:0]      ADDR_LIMIT = 31'(DEPTH * BYTES_PER_WORD);
  localparam logic [TW-1:0]    TMO_LAST   = TW'(TIMEOUT - 1);

  state_t              state, state_n;
  logic [COUNT_W-1:0]  count, count_n;
  logic [COUNT_W-1:0]  widx, widx_n;
  logic [1:0]          bidx, bidx_n;
  logic [23:0]         asm_q, asm_n;
  logic [TW-1:0]       tmo, tmo_n;
  logic                done_q, done_n;
  logic                we;
  logic [COUNT_W-1:0]  len;
  logic                tmo_hit;
  logic [AW-1:0]       ram_addr;
  logic [31:0]         ram_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= LEN_HI;
      count  <= '0;
      widx   <= '0;
      bidx   <= '0;
      asm_q  <= '0;
      tmo    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      count  <= count_n;
      widx   <= widx_n;
      bidx   <= bidx_n;
      asm_q  <= asm_n;
      tmo    <= tmo_n;
      done_q <= done_n;
    end
  end

  assign len     = {count[15:8], bus.rx_data};
  assign tmo_hit = !bus.rx_valid && (tmo == TMO_LAST);

  always_comb begin
    state_n = state;
    count_n = count;
    widx_n  = widx;
    bidx_n  = bidx;
    asm_n   = asm_q;
    done_n  = done_q;
    we      = 1'b0;
    // boot_req outranks any byte arriving in the same cycle
    if (bus.boot_req) begin
      state_n = LEN_HI;
      count_n = '0;
      widx_n  = '0;
      bidx_n  = '0;
      asm_n   = '0;
      done_n  = 1'b0;
    end else begin
      unique case (state)
        LEN_HI: if (bus.rx_valid) begin
          count_n = {bus.rx_data, 8'h00};
          state_n = LEN_LO;
        end
        LEN_LO: if (bus.rx_valid) begin
          count_n = len;
          if (len == '0) begin
            state_n = RUN;
            done_n  = 1'b1;
          end else if (len > COUNT_W'(DEPTH)) begin
            state_n = ERR;
          end else begin
            state_n = DATA;
            widx_n  = '0;
            bidx_n  = '0;
          end
        end else if (tmo_hit) begin
          state_n = ERR;
        end
        DATA: if (bus.rx_valid) begin
          asm_n  = {asm_q[15:0], bus.rx_data};
          bidx_n = bidx + 2'd1;
          if (bidx == 2'd3) begin
            we     = 1'b1;
            widx_n = widx + 1'b1;
            if (widx == count - 1'b1) begin
              state_n = RUN;
              done_n  = 1'b1;
            end
          end
        end else if (tmo_hit) begin
          state_n = ERR;
        end
        default: ;
      endcase
    end
    if (state_n != state || bus.rx_valid) tmo_n = '0;
    else if (state == LEN_LO || state == DATA) tmo_n = tmo + 1'b1;
    else tmo_n = '0;
  end

  assign bus.cpu_hold  = (state != RUN);
  assign bus.load_done = done_q;
  assign bus.load_err  = (state == ERR);

  // Single address port: loader owns it while the cpu is held.
  assign ram_addr = bus.cpu_hold ? widx[AW-1:0] : bus.cpu_addr[AW+1:2];

  imem_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (we),
    .addr  (ram_addr),
    .wdata ({asm_q, bus.rx_data}),
    .rdata (ram_rdata)
  );

  assign bus.cpu_data = (!bus.cpu_hold && bus.cpu_addr < ADDR_LIMIT) ? ram_rdata : 32'h0;

endmodule
